// File: rtl/flag_pkg.sv
// Shared types and constants for the flag controller: difficulty levels,
// controller states and the board-side lookup.
package flag_pkg;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'd0,
    LVL_EASY   = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HARD   = 2'd3
  } level_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int SIDE_EASY   = 8;
  localparam int SIDE_MEDIUM = 10;
  localparam int SIDE_HARD   = 16;

  // Board side for a level; 0 for LVL_NONE so every coordinate is out of range.
  function automatic logic [4:0] board_side(input level_t lvl);
    case (lvl)
      LVL_EASY:   return 5'(SIDE_EASY);
      LVL_MEDIUM: return 5'(SIDE_MEDIUM);
      LVL_HARD:   return 5'(SIDE_HARD);
      default:    return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/flag_ctl.sv
// Per-cell flag state for the overlay renderer: toggles flags on the active
// level's array under a mine-count budget, and row-sweeps all arrays on new game.
module flag_ctl
  import flag_pkg::*;
#(
  parameter int MAX_DIM = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  level_t                 level,
  input  logic                   new_game,
  input  logic                   game_over,
  input  logic [CNT_W-1:0]       max_flags,
  input  logic                   tgl_req,
  input  logic [3:0]             tgl_x,
  input  logic [3:0]             tgl_y,
  input  logic                   tgl_revealed,
  output logic                   tgl_ack,
  output logic                   tgl_done,
  output logic                   busy,
  output logic [CNT_W-1:0]       flags_left,
  output logic [7:0][7:0]        flag_arr_easy,
  output logic [9:0][9:0]        flag_arr_medium,
  output logic [15:0][15:0]      flag_arr_hard
);

  localparam int ROW_W = $clog2(MAX_DIM);

  state_t             state;
  state_t             state_next;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   budget;
  logic               latch_budget;

  logic [MAX_DIM-1:0] row_oh;
  logic [63:0]        flip_easy;
  logic [99:0]        flip_medium;
  logic [255:0]       flip_hard;
  logic [4:0]         side;
  logic               in_range;
  logic               cur_bit;
  logic               accept;

  // Arrays are handled as flat vectors: element [x][y] sits at bit x*side+y,
  // so a whole row y is the one-hot row pattern replicated once per column.
  assign row_oh      = MAX_DIM'(1) << row;
  assign flip_easy   = 64'd1 << {tgl_x[2:0], tgl_y[2:0]};
  assign flip_medium = 100'd1 << (7'(tgl_x) * 7'd10 + 7'(tgl_y));
  assign flip_hard   = 256'd1 << {tgl_x, tgl_y};

  assign side     = board_side(level);
  assign in_range = ({1'b0, tgl_x} < side) && ({1'b0, tgl_y} < side);

  always_comb begin
    cur_bit = 1'b0;
    case (level)
      LVL_EASY:   cur_bit = |(flag_arr_easy & flip_easy);
      LVL_MEDIUM: cur_bit = |(flag_arr_medium & flip_medium);
      LVL_HARD:   cur_bit = |(flag_arr_hard & flip_hard);
      default:    cur_bit = 1'b0;
    endcase
  end

  // Clearing a flag is always legal in range; placing one needs a covered cell and budget.
  always_comb begin
    accept = 1'b0;
    if (level != LVL_NONE && !game_over && in_range) begin
      accept = cur_bit ? 1'b1 : (!tgl_revealed && flags_left != '0);
    end
  end

  always_comb begin
    state_next   = state;
    latch_budget = 1'b0;
    case (state)
      IDLE: begin
        if (new_game) begin
          state_next   = CLEAR;
          latch_budget = 1'b1;
        end else if (tgl_req && !tgl_ack) begin
          // The ack cycle still sees the old request; ignore it.
          state_next = EXEC;
        end
      end
      CLEAR: begin
        if (new_game) begin
          latch_budget = 1'b1;
        end else if (row == ROW_W'(MAX_DIM - 1)) begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        state_next   = new_game ? CLEAR : IDLE;
        latch_budget = new_game;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      budget          <= '0;
      flags_left      <= '0;
      tgl_ack         <= 1'b0;
      tgl_done        <= 1'b0;
      busy            <= 1'b0;
      flag_arr_easy   <= '0;
      flag_arr_medium <= '0;
      flag_arr_hard   <= '0;
    end else begin
      state    <= state_next;
      busy     <= (state_next == CLEAR);
      tgl_ack  <= (state == EXEC);
      tgl_done <= (state == EXEC) && accept;

      if (latch_budget) begin
        budget <= max_flags;
        row    <= '0;
      end else if (state == CLEAR) begin
        row <= row + 1'b1;
      end

      if (state == CLEAR) begin
        flag_arr_easy   <= flag_arr_easy   & ~{8{row_oh[7:0]}};
        flag_arr_medium <= flag_arr_medium & ~{10{row_oh[9:0]}};
        flag_arr_hard   <= flag_arr_hard   & ~{16{row_oh[15:0]}};
        if (state_next == IDLE) begin
          flags_left <= budget;
        end
      end else if (state == EXEC && accept) begin
        case (level)
          LVL_EASY:   flag_arr_easy   <= flag_arr_easy ^ flip_easy;
          LVL_MEDIUM: flag_arr_medium <= flag_arr_medium ^ flip_medium;
          LVL_HARD:   flag_arr_hard   <= flag_arr_hard ^ flip_hard;
          default:    ;
        endcase
        if (!cur_bit) begin
          flags_left <= flags_left - 1'b1;
        end else if (flags_left < budget) begin
          flags_left <= flags_left + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_ctl.sv
// Scoreboard bench for flag_ctl: directed scenarios plus random games checked
// against a cell/budget model of the flag rules.
module tb_flag_ctl;
  import flag_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  level_t            level;
  logic              new_game;
  logic              game_over;
  logic [7:0]        max_flags;
  logic              tgl_req;
  logic [3:0]        tgl_x;
  logic [3:0]        tgl_y;
  logic              tgl_revealed;
  logic              tgl_ack;
  logic              tgl_done;
  logic              busy;
  logic [7:0]        flags_left;
  logic [7:0][7:0]   flag_arr_easy;
  logic [9:0][9:0]   flag_arr_medium;
  logic [15:0][15:0] flag_arr_hard;

  flag_ctl #(.MAX_DIM(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .level(level), .new_game(new_game),
    .game_over(game_over), .max_flags(max_flags), .tgl_req(tgl_req),
    .tgl_x(tgl_x), .tgl_y(tgl_y), .tgl_revealed(tgl_revealed),
    .tgl_ack(tgl_ack), .tgl_done(tgl_done), .busy(busy),
    .flags_left(flags_left), .flag_arr_easy(flag_arr_easy),
    .flag_arr_medium(flag_arr_medium), .flag_arr_hard(flag_arr_hard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         done;
    logic [7:0]   left;
    logic [63:0]  e;
    logic [99:0]  m;
    logic [255:0] h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one bit per cell per level, plus the flag budget.
  logic [7:0][7:0]   me;
  logic [9:0][9:0]   mm;
  logic [15:0][15:0] mh;
  int                m_left;
  int                m_budget;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear(input int budget);
    me = '0; mm = '0; mh = '0;
    m_budget = budget;
    m_left   = budget;
  endtask

  task automatic model_toggle(input int x, input int y, input bit rev, output logic done);
    int   side;
    logic cur;
    done = 1'b0;
    side = (level == LVL_EASY) ? 8 : (level == LVL_MEDIUM) ? 10 : (level == LVL_HARD) ? 16 : 0;
    if (side == 0 || game_over || x >= side || y >= side) return;
    case (level)
      LVL_EASY:   cur = me[x][y];
      LVL_MEDIUM: cur = mm[x][y];
      default:    cur = mh[x][y];
    endcase
    if (!cur && (rev || m_left == 0)) return;
    case (level)
      LVL_EASY:   me[x][y] = ~cur;
      LVL_MEDIUM: mm[x][y] = ~cur;
      default:    mh[x][y] = ~cur;
    endcase
    if (!cur) m_left--;
    else if (m_left < m_budget) m_left++;
    done = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_flags_left"}, flags_left, 8'(m_left));
    chk({tag, "_easy"}, flag_arr_easy, me);
    chk({tag, "_medium"}, flag_arr_medium, mm);
    chk({tag, "_hard"}, flag_arr_hard, mh);
  endtask

  // Monitor: every ack pops one expectation; array/counter are checked a cycle later.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (tgl_ack === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack 1 expected no ack");
        end else begin
          e = sb.pop_front();
          chk("tgl_done", tgl_done, e.done);
          @(negedge clk);
          chk("ack_flags_left", flags_left, e.left);
          chk("ack_easy", flag_arr_easy, e.e);
          chk("ack_medium", flag_arr_medium, e.m);
          chk("ack_hard", flag_arr_hard, e.h);
        end
      end
    end
  end

  task automatic toggle(input int x, input int y, input bit rev);
    logic d;
    exp_t e;
    int   n;
    model_toggle(x, y, rev, d);
    e.done = d; e.left = 8'(m_left); e.e = me; e.m = mm; e.h = mh;
    sb.push_back(e);
    tgl_x = 4'(x); tgl_y = 4'(y); tgl_revealed = rev; tgl_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tgl_ack !== 1'b1 && n < 20);
    tgl_req = 1'b0;
    if (tgl_ack !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", n);
      sb.delete();
    end
    $display("toggle lvl=%0d (%0d,%0d) rev=%0d go=%0d -> exp done=%0d left=%0d",
             level, x, y, rev, game_over, d, m_left);
    repeat (2) @(negedge clk);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 256'(n), 256'(16));
  endtask

  task automatic start_game(input level_t lv, input int budget);
    level = lv; max_flags = 8'(budget); new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    count_busy("new_game");
    model_clear(budget);
    chk_state("new_game");
    $display("new_game lvl=%0d budget=%0d", lv, budget);
  endtask

  initial begin
    rst = 1'b1; level = LVL_NONE; new_game = 1'b0; game_over = 1'b0;
    max_flags = '0; tgl_req = 1'b0; tgl_x = '0; tgl_y = '0; tgl_revealed = 1'b0;
    model_clear(0);
    repeat (3) @(negedge clk);
    chk("reset_ack", tgl_ack, 1'b0);
    chk("reset_done", tgl_done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic set/clear on easy.
    start_game(LVL_EASY, 10);
    toggle(3, 5, 0);
    toggle(3, 5, 0);

    // Budget exhaustion and recovery.
    start_game(LVL_EASY, 2);
    toggle(0, 0, 0);
    toggle(1, 1, 0);
    toggle(2, 2, 0);
    toggle(1, 1, 0);
    toggle(2, 2, 0);

    // Out-of-range on easy; corner of hard.
    toggle(9, 2, 0);
    start_game(LVL_HARD, 40);
    toggle(15, 15, 0);

    // Revealed cell, and freeze while game over.
    toggle(4, 4, 1);
    toggle(4, 4, 0);
    game_over = 1'b1;
    toggle(4, 4, 0);
    toggle(6, 6, 0);
    game_over = 1'b0;

    // Medium edges.
    start_game(LVL_MEDIUM, 3);
    toggle(9, 9, 0);
    toggle(10, 0, 0);
    toggle(0, 10, 0);

    // Random games.
    for (int g = 0; g < 8; g++) begin
      start_game(level_t'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      for (int t = 0; t < 14; t++) begin
        int lim;
        lim = ($urandom_range(0, 1) == 1) ? 15 : 3;
        game_over = ($urandom_range(0, 7) == 0);
        toggle(int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
               ($urandom_range(0, 3) == 0));
      end
      game_over = 1'b0;
    end

    // new_game while the sweep is at row 7 restarts the full sweep.
    start_game(LVL_HARD, 9);
    toggle(7, 3, 0);
    toggle(12, 14, 0);
    level = LVL_HARD; max_flags = 8'd9; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    repeat (7) @(negedge clk);
    max_flags = 8'd5; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    count_busy("restart");
    model_clear(5);
    chk_state("restart");
    $display("new_game restart at row 7 budget=5");

    // Asynchronous reset while a toggle is in EXEC.
    toggle(2, 2, 0);
    tgl_x = 4'd8; tgl_y = 4'd8; tgl_revealed = 1'b0; tgl_req = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_clear(0);
    chk("async_rst_ack", tgl_ack, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk_state("async_rst");
    tgl_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_state("post_rst");
    $display("async reset during EXEC");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
